// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, I-cache request and a
// small circular FIFO of {inst, pc} drained by the decoder, flushed on redirect.
module fetch_queue #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 17,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  icache_ce,
    output logic [ADDR_WIDTH-1:0] icache_addr,
    input  logic                  icache_stall,
    input  logic                  icache_valid,
    input  logic [INST_WIDTH-1:0] icache_inst,
    output logic                  dec_valid,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  dec_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic [INST_WIDTH-1:0] mem_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];

    logic push;
    logic pop;

    // A full queue never requests, even if the decoder frees a slot this cycle.
    assign icache_ce   = rst & ~redirect & (count != FULL_CNT);
    assign icache_addr = pc;
    assign push        = icache_ce & ~icache_stall & icache_valid;

    assign dec_valid = (count != '0);
    assign pop       = dec_valid & dec_ready & ~redirect;
    assign dec_inst  = dec_valid ? mem_inst[head] : '0;
    assign dec_pc    = dec_valid ? mem_pc[head]   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            pc    <= redirect_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc   <= pc + ADDR_WIDTH'(4);
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; dec_valid gates what the decoder sees.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[tail] <= icache_inst;
            mem_pc[tail]   <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected PCs into a queue,
// an independent monitor compares every decoder handoff against it.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        icache_ce;
    logic [16:0] icache_addr;
    logic        icache_stall;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [16:0] dec_pc;
    logic        dec_ready;
    logic        redirect;
    logic [16:0] redirect_pc;

    int n_chk  = 0;
    int n_fail = 0;
    logic [16:0] exp_q[$];

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .icache_ce   (icache_ce),
        .icache_addr (icache_addr),
        .icache_stall(icache_stall),
        .icache_valid(icache_valid),
        .icache_inst (icache_inst),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [16:0] a);
        return 32'hC0DE_0000 ^ {15'd0, a};
    endfunction

    // Cache stub: returns a PC-derived word so each entry is identifiable.
    assign icache_inst = icache_valid ? inst_of(icache_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && dec_valid && dec_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h expected none", dec_pc);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("mon_pc", {15'd0, dec_pc}, {15'd0, e});
                chk("mon_inst", dec_inst, inst_of(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] wrap_pcs [4];
        rst = 1'b0; dec_ready = 1'b0; icache_valid = 1'b0; icache_stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        wrap_pcs[0] = 17'h1FFF8; wrap_pcs[1] = 17'h1FFFC;
        wrap_pcs[2] = 17'h00000; wrap_pcs[3] = 17'h00004;

        #2;
        chk("rst_ce", {31'd0, icache_ce}, 32'd0);
        chk("rst_addr", {15'd0, icache_addr}, 32'd0);
        chk("rst_dv", {31'd0, dec_valid}, 32'd0);
        chk("rst_inst", dec_inst, 32'd0);
        chk("rst_pc", {15'd0, dec_pc}, 32'd0);

        // free run from reset
        cyc(); cyc();
        rst = 1'b1; icache_valid = 1'b1; dec_ready = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(17'(4 * k));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("run_addr", {15'd0, icache_addr}, 32'(4 * k));
            chk("run_ce", {31'd0, icache_ce}, 32'd1);
            chk("run_dv", {31'd0, dec_valid}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) chk("run_dpc", {15'd0, dec_pc}, 32'(4 * (k - 1)));
            cyc();
        end
        icache_valid = 1'b0; #1;
        chk("run_last", {15'd0, dec_pc}, 32'h14);
        cyc();

        // fill to full from pc 0
        redirect = 1'b1; redirect_pc = 17'h0; #1;
        chk("redir0_ce", {31'd0, icache_ce}, 32'd0);
        cyc();
        redirect = 1'b0; dec_ready = 1'b0; icache_valid = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(17'(4 * k));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_addr", {15'd0, icache_addr}, 32'(4 * k));
            chk("fill_ce", {31'd0, icache_ce}, 32'd1);
            cyc();
        end
        #1;
        chk("full_ce", {31'd0, icache_ce}, 32'd0);
        chk("full_addr", {15'd0, icache_addr}, 32'h10);
        chk("full_dpc", {15'd0, dec_pc}, 32'h0);
        cyc();
        dec_ready = 1'b1; #1;
        chk("full_pop_ce", {31'd0, icache_ce}, 32'd0);
        cyc();
        dec_ready = 1'b0; #1;
        chk("refill_ce", {31'd0, icache_ce}, 32'd1);
        chk("refill_addr", {15'd0, icache_addr}, 32'h10);
        chk("refill_dpc", {15'd0, dec_pc}, 32'h4);
        cyc();
        #1;
        chk("refull_ce", {31'd0, icache_ce}, 32'd0);
        chk("refull_addr", {15'd0, icache_addr}, 32'h14);
        icache_valid = 1'b0; dec_ready = 1'b1;
        repeat (4) cyc();
        #1;
        chk("drain_dv", {31'd0, dec_valid}, 32'd0);

        // cache stall at pc 0x8
        redirect = 1'b1; redirect_pc = 17'h8;
        cyc();
        redirect = 1'b0; icache_valid = 1'b1; icache_stall = 1'b1;
        exp_q.push_back(17'h8); exp_q.push_back(17'hC);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_addr", {15'd0, icache_addr}, 32'h8);
            chk("stall_ce", {31'd0, icache_ce}, 32'd1);
            chk("stall_dv", {31'd0, dec_valid}, 32'd0);
            cyc();
        end
        icache_stall = 1'b0; #1;
        chk("unstall_dv", {31'd0, dec_valid}, 32'd0);
        cyc();
        #1;
        chk("unstall_dv1", {31'd0, dec_valid}, 32'd1);
        chk("unstall_dpc", {15'd0, dec_pc}, 32'h8);
        chk("unstall_addr", {15'd0, icache_addr}, 32'hC);
        cyc();
        icache_valid = 1'b0; #1;
        chk("stall_next_dpc", {15'd0, dec_pc}, 32'hC);
        cyc();
        #1;
        chk("stall_end_dv", {31'd0, dec_valid}, 32'd0);
        chk("stall_end_addr", {15'd0, icache_addr}, 32'h10);

        // redirect with three entries queued
        dec_ready = 1'b0; icache_valid = 1'b1;
        repeat (3) cyc();
        icache_valid = 1'b0; dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 17'h100; #1;
        chk("redir_ce", {31'd0, icache_ce}, 32'd0);
        chk("redir_dv", {31'd0, dec_valid}, 32'd1);
        chk("redir_dpc", {15'd0, dec_pc}, 32'h10);
        cyc();
        redirect = 1'b0; icache_valid = 1'b1;
        exp_q.push_back(17'h100); #1;
        chk("flush_dv", {31'd0, dec_valid}, 32'd0);
        chk("flush_addr", {15'd0, icache_addr}, 32'h100);
        chk("flush_ce", {31'd0, icache_ce}, 32'd1);
        cyc();
        icache_valid = 1'b0; #1;
        chk("flush_first_dv", {31'd0, dec_valid}, 32'd1);
        chk("flush_first_dpc", {15'd0, dec_pc}, 32'h100);
        cyc();
        #1;
        chk("flush_end_dv", {31'd0, dec_valid}, 32'd0);
        chk("flush_end_addr", {15'd0, icache_addr}, 32'h104);

        // address and pointer wrap-around
        dec_ready = 1'b0; redirect = 1'b1; redirect_pc = 17'h1FFF8;
        cyc();
        redirect = 1'b0; icache_valid = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(wrap_pcs[k]);
        for (int k = 0; k < 5; k++) exp_q.push_back(17'(8 + 4 * k));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wrap_addr", {15'd0, icache_addr}, {15'd0, wrap_pcs[k]});
            cyc();
        end
        #1;
        chk("wrap_full_ce", {31'd0, icache_ce}, 32'd0);
        chk("wrap_full_addr", {15'd0, icache_addr}, 32'h8);
        dec_ready = 1'b1;
        repeat (6) cyc();
        icache_valid = 1'b0;
        repeat (3) cyc();
        #1;
        chk("wrap_end_dv", {31'd0, dec_valid}, 32'd0);
        chk("wrap_end_addr", {15'd0, icache_addr}, 32'h1C);

        // asynchronous reset with two entries queued
        dec_ready = 1'b0; icache_valid = 1'b1;
        cyc(); cyc();
        icache_valid = 1'b0; #1;
        chk("pre_rst_dv", {31'd0, dec_valid}, 32'd1);
        chk("pre_rst_dpc", {15'd0, dec_pc}, 32'h1C);
        #1;
        rst = 1'b0; #1;
        chk("arst_dv", {31'd0, dec_valid}, 32'd0);
        chk("arst_ce", {31'd0, icache_ce}, 32'd0);
        chk("arst_addr", {15'd0, icache_addr}, 32'd0);
        chk("arst_dpc", {15'd0, dec_pc}, 32'd0);
        cyc();
        rst = 1'b1; icache_valid = 1'b1; dec_ready = 1'b1;
        exp_q.push_back(17'h0); #1;
        chk("post_rst_addr", {15'd0, icache_addr}, 32'd0);
        chk("post_rst_ce", {31'd0, icache_ce}, 32'd1);
        cyc();
        icache_valid = 1'b0; #1;
        chk("post_rst_dpc", {15'd0, dec_pc}, 32'd0);
        cyc();
        #1;
        chk("post_rst_dv", {31'd0, dec_valid}, 32'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
